// File: rtl/trap_controller_if.sv
// Trap controller bus: exception/interrupt sources, CSR port and fetch redirect.
// The pipeline side uses master; the trap controller uses slave.
interface trap_controller_if #(
    parameter int N = 64
);
    logic [15:0]  excSrc;
    logic [N-1:0] excPC;
    logic [N-1:0] excTval;
    logic         irqSoft;
    logic         irqTimer;
    logic         irqExt;
    logic         mretValid;
    logic [N-1:0] mstatus;
    logic [1:0]   currentMode;
    logic         csrWrEnable;
    logic [11:0]  csrAddr;
    logic [N-1:0] csrIn;
    logic [N-1:0] csrRdData;
    logic [15:0]  trapTrigger;
    logic         trapReturn;
    logic         trapBusy;
    logic         redirectValid;
    logic [N-1:0] redirectPC;
    logic         redirectReady;

    modport master (
        output excSrc, excPC, excTval, irqSoft, irqTimer, irqExt, mretValid,
               mstatus, currentMode, csrWrEnable, csrAddr, csrIn, redirectReady,
        input  csrRdData, trapTrigger, trapReturn, trapBusy, redirectValid, redirectPC
    );

    modport slave (
        input  excSrc, excPC, excTval, irqSoft, irqTimer, irqExt, mretValid,
               mstatus, currentMode, csrWrEnable, csrAddr, csrIn, redirectReady,
        output csrRdData, trapTrigger, trapReturn, trapBusy, redirectValid, redirectPC
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: selects a cause, latches mepc/mcause/mtval,
// signals the mstatus tracker and redirects fetch to mtvec or mepc.
//
//  state  | meaning
//  IDLE   | waiting for an exception, enabled interrupt or mret
//  TAKE   | trapTrigger pulse, trap target computed
//  TAKE_R | trapReturn pulse, mepc selected as target
//  REDIR  | redirect held until fetch accepts it
module trap_controller #(
    parameter int           N         = 64,
    parameter logic [N-1:0] MTVEC_RST = '0
) (
    input logic              clk,
    input logic              reset,
    trap_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, TAKE, TAKE_R, REDIR} state_t;

    localparam logic [3:0] EXC_ORDER [16] = '{
        4'd3, 4'd1, 4'd0, 4'd2, 4'd11, 4'd9, 4'd8, 4'd6,
        4'd4, 4'd7, 4'd5, 4'd10, 4'd12, 4'd13, 4'd14, 4'd15
    };

    state_t       state;
    logic [N-1:0] mie, mtvec, mepc, mcause, mtval;
    logic [3:0]   cause_code;
    logic         cause_irq;
    logic [15:0]  trap_trigger;
    logic         trap_return;
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;

    logic         exc_found, irq_found, irq_on, take_trap;
    logic [3:0]   exc_code, irq_code, sel_code;
    logic [N-1:0] mip, trap_target, csr_rd;
    logic         unused_bits;

    assign unused_bits = ^{bus.mstatus[N-1:4], bus.mstatus[2:0], bus.excPC[1:0]};

    always_comb begin
        exc_found = 1'b0;
        exc_code  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!exc_found && bus.excSrc[EXC_ORDER[i]]) begin
                exc_found = 1'b1;
                exc_code  = EXC_ORDER[i];
            end
        end
    end

    always_comb begin
        mip     = '0;
        mip[11] = bus.irqExt;
        mip[7]  = bus.irqTimer;
        mip[3]  = bus.irqSoft;
        irq_on  = bus.mstatus[3] | (bus.currentMode != 2'b11);
        irq_found = 1'b1;
        irq_code  = 4'd0;
        if (irq_on && mie[11] && mip[11])     irq_code = 4'd11;
        else if (irq_on && mie[3] && mip[3])  irq_code = 4'd3;
        else if (irq_on && mie[7] && mip[7])  irq_code = 4'd7;
        else                                  irq_found = 1'b0;
    end

    // An exception always wins; an mret beats a pending interrupt, which is
    // re-evaluated once the return has completed.
    assign take_trap = exc_found | (irq_found & ~bus.mretValid);
    assign sel_code  = exc_found ? exc_code : irq_code;

    always_comb begin
        trap_target = {mtvec[N-1:2], 2'b00};
        if (mtvec[1:0] == 2'd1 && cause_irq)
            trap_target = trap_target + ({{(N-4){1'b0}}, cause_code} << 2);
    end

    always_comb begin
        case (bus.csrAddr)
            12'h304: csr_rd = mie;
            12'h305: csr_rd = mtvec;
            12'h341: csr_rd = mepc;
            12'h342: csr_rd = mcause;
            12'h343: csr_rd = mtval;
            12'h344: csr_rd = mip;
            default: csr_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            mie            <= '0;
            mtvec          <= MTVEC_RST;
            mepc           <= '0;
            mcause         <= '0;
            mtval          <= '0;
            cause_code     <= 4'd0;
            cause_irq      <= 1'b0;
            trap_trigger   <= '0;
            trap_return    <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            trap_trigger <= '0;
            trap_return  <= 1'b0;
            if (bus.csrWrEnable) begin
                case (bus.csrAddr)
                    12'h304: mie    <= bus.csrIn;
                    12'h305: mtvec  <= {bus.csrIn[N-1:2], 1'b0, bus.csrIn[1:0] == 2'd1};
                    12'h341: mepc   <= {bus.csrIn[N-1:2], 2'b00};
                    12'h342: mcause <= bus.csrIn;
                    12'h343: mtval  <= bus.csrIn;
                    default: ;
                endcase
            end
            // Trap latch is written after the CSR write so it takes precedence.
            case (state)
                IDLE: begin
                    if (take_trap) begin
                        mepc         <= {bus.excPC[N-1:2], 2'b00};
                        mcause       <= {~exc_found, {(N-5){1'b0}}, sel_code};
                        mtval        <= exc_found ? bus.excTval : '0;
                        cause_code   <= sel_code;
                        cause_irq    <= ~exc_found;
                        trap_trigger <= 16'd1 << sel_code;
                        state        <= TAKE;
                    end else if (bus.mretValid) begin
                        trap_return <= 1'b1;
                        state       <= TAKE_R;
                    end
                end
                TAKE: begin
                    redirect_pc    <= trap_target;
                    redirect_valid <= 1'b1;
                    state          <= REDIR;
                end
                TAKE_R: begin
                    redirect_pc    <= mepc;
                    redirect_valid <= 1'b1;
                    state          <= REDIR;
                end
                REDIR: begin
                    if (bus.redirectReady) begin
                        redirect_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.csrRdData     = csr_rd;
    assign bus.trapTrigger   = trap_trigger;
    assign bus.trapReturn    = trap_return;
    assign bus.trapBusy      = (state != IDLE);
    assign bus.redirectValid = redirect_valid;
    assign bus.redirectPC    = redirect_pc;
endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: exception/interrupt selection, CSR
// side effects, mret redirect stall and synchronous reset mid-sequence.
module tb_trap_controller;
    localparam int N = 64;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    trap_controller_if #(.N(N)) bus();

    trap_controller #(.N(N), .MTVEC_RST(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [N-1:0] data);
        bus.csrWrEnable = 1'b1;
        bus.csrAddr     = addr;
        bus.csrIn       = data;
        tick();
        bus.csrWrEnable = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [N-1:0] data);
        bus.csrAddr = addr;
        #1;
        data = bus.csrRdData;
    endtask

    task automatic idle_inputs();
        bus.excSrc        = '0;
        bus.excPC         = '0;
        bus.excTval       = '0;
        bus.irqSoft       = 1'b0;
        bus.irqTimer      = 1'b0;
        bus.irqExt        = 1'b0;
        bus.mretValid     = 1'b0;
        bus.mstatus       = '0;
        bus.currentMode   = 2'b11;
        bus.csrWrEnable   = 1'b0;
        bus.csrAddr       = '0;
        bus.csrIn         = '0;
        bus.redirectReady = 1'b1;
    endtask

    task automatic test_reset();
        logic [N-1:0] d;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.trapTrigger, bus.trapReturn, bus.trapBusy, bus.redirectValid} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {bus.trapTrigger, bus.trapReturn, bus.trapBusy, bus.redirectValid});
        end
        checks++;
        if (bus.redirectPC !== 64'h0) begin
            failures++;
            $display("FAIL reset_redirect_pc got=%h exp=0", bus.redirectPC);
        end
        reset = 1'b0;
        csr_read(12'h305, d);
        checks++;
        if (d !== 64'h0) begin failures++; $display("FAIL reset_mtvec got=%h exp=0", d); end
        csr_read(12'h341, d);
        checks++;
        if (d !== 64'h0) begin failures++; $display("FAIL reset_mepc got=%h exp=0", d); end
    endtask

    task automatic test_exception();
        logic [N-1:0] d;
        csr_write(12'h305, 64'h1000);
        bus.excSrc  = 16'h0004;
        bus.excPC   = 64'h2006;
        bus.excTval = 64'hDEAD;
        tick();
        bus.excSrc = '0;
        checks++;
        if (bus.trapTrigger !== 16'h0004) begin
            failures++; $display("FAIL exc_trigger got=%h exp=0004", bus.trapTrigger);
        end
        csr_read(12'h341, d);
        checks++;
        if (d !== 64'h2004) begin failures++; $display("FAIL exc_mepc got=%h exp=2004", d); end
        csr_read(12'h342, d);
        checks++;
        if (d !== 64'h2) begin failures++; $display("FAIL exc_mcause got=%h exp=2", d); end
        csr_read(12'h343, d);
        checks++;
        if (d !== 64'hDEAD) begin failures++; $display("FAIL exc_mtval got=%h exp=DEAD", d); end
        tick();
        checks++;
        if ({bus.trapTrigger, bus.redirectValid} !== {16'h0, 1'b1} || bus.redirectPC !== 64'h1000) begin
            failures++;
            $display("FAIL exc_redirect trig=%h valid=%b pc=%h exp trig=0 valid=1 pc=1000",
                     bus.trapTrigger, bus.redirectValid, bus.redirectPC);
        end
        tick();
        checks++;
        if ({bus.redirectValid, bus.trapBusy} !== 2'b00) begin
            failures++;
            $display("FAIL exc_done valid/busy got=%b%b exp=00", bus.redirectValid, bus.trapBusy);
        end
    endtask

    task automatic test_priority();
        logic [N-1:0] d;
        csr_write(12'h304, 64'h800);
        bus.mstatus = 64'h8;
        bus.irqExt  = 1'b1;
        bus.excSrc  = 16'h0809;
        bus.excPC   = 64'h4000;
        tick();
        bus.excSrc = '0;
        bus.irqExt = 1'b0;
        checks++;
        if (bus.trapTrigger !== 16'h0008) begin
            failures++; $display("FAIL prio_trigger got=%h exp=0008", bus.trapTrigger);
        end
        csr_read(12'h342, d);
        checks++;
        if (d !== 64'h3) begin failures++; $display("FAIL prio_mcause got=%h exp=3", d); end
        tick();
        tick();
    endtask

    task automatic test_vectored_irq();
        logic [N-1:0] d;
        csr_write(12'h305, 64'h1001);
        csr_write(12'h304, 64'h80);
        bus.mstatus  = 64'h8;
        bus.irqTimer = 1'b1;
        bus.excPC    = 64'h5008;
        tick();
        bus.irqTimer = 1'b0;
        checks++;
        if (bus.trapTrigger !== 16'h0080) begin
            failures++; $display("FAIL virq_trigger got=%h exp=0080", bus.trapTrigger);
        end
        csr_read(12'h342, d);
        checks++;
        if (d !== 64'h8000_0000_0000_0007) begin
            failures++; $display("FAIL virq_mcause got=%h exp=8000000000000007", d);
        end
        csr_read(12'h343, d);
        checks++;
        if (d !== 64'h0) begin failures++; $display("FAIL virq_mtval got=%h exp=0", d); end
        tick();
        checks++;
        if (bus.redirectPC !== 64'h101C) begin
            failures++; $display("FAIL virq_target got=%h exp=101C", bus.redirectPC);
        end
        tick();
        bus.mstatus = '0;
    endtask

    task automatic test_mret_stall();
        logic [N-1:0] d;
        csr_write(12'h341, 64'h3003);
        csr_read(12'h341, d);
        checks++;
        if (d !== 64'h3000) begin failures++; $display("FAIL mepc_mask got=%h exp=3000", d); end
        bus.redirectReady = 1'b0;
        bus.mretValid     = 1'b1;
        tick();
        bus.mretValid = 1'b0;
        checks++;
        if ({bus.trapReturn, bus.trapTrigger} !== {1'b1, 16'h0}) begin
            failures++;
            $display("FAIL mret_pulse ret=%b trig=%h exp ret=1 trig=0", bus.trapReturn, bus.trapTrigger);
        end
        tick();
        checks++;
        if (bus.trapReturn !== 1'b0) begin
            failures++; $display("FAIL mret_pulse_width got=%b exp=0", bus.trapReturn);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.redirectValid !== 1'b1 || bus.redirectPC !== 64'h3000) begin
                failures++;
                $display("FAIL mret_hold[%0d] valid=%b pc=%h exp valid=1 pc=3000",
                         i, bus.redirectValid, bus.redirectPC);
            end
            tick();
        end
        bus.redirectReady = 1'b1;
        tick();
        checks++;
        if (bus.redirectValid !== 1'b0) begin
            failures++; $display("FAIL mret_release got=%b exp=0", bus.redirectValid);
        end
    endtask

    task automatic test_irq_gating();
        logic [N-1:0] d;
        csr_write(12'h304, 64'h800);
        bus.mstatus     = '0;
        bus.currentMode = 2'b11;
        bus.irqExt      = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.trapTrigger, bus.trapBusy} !== 17'd0) begin
            failures++;
            $display("FAIL gate_masked trig=%h busy=%b exp 0", bus.trapTrigger, bus.trapBusy);
        end
        csr_read(12'h344, d);
        checks++;
        if (d !== 64'h800) begin failures++; $display("FAIL gate_mip got=%h exp=800", d); end
        bus.currentMode = 2'b00;
        tick();
        bus.irqExt      = 1'b0;
        bus.currentMode = 2'b11;
        checks++;
        if (bus.trapTrigger !== 16'h0800) begin
            failures++; $display("FAIL gate_umode_trigger got=%h exp=0800", bus.trapTrigger);
        end
        csr_read(12'h342, d);
        checks++;
        if (d !== 64'h8000_0000_0000_000B) begin
            failures++; $display("FAIL gate_umode_mcause got=%h exp=800000000000000B", d);
        end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] d;
        csr_write(12'h305, 64'h1002);
        csr_read(12'h305, d);
        checks++;
        if (d !== 64'h1000) begin failures++; $display("FAIL mtvec_mode_clip got=%h exp=1000", d); end
        bus.excSrc      = 16'h0010;
        bus.excPC       = 64'h6000;
        bus.mretValid   = 1'b1;
        bus.csrWrEnable = 1'b1;
        bus.csrAddr     = 12'h342;
        bus.csrIn       = 64'h55;
        tick();
        bus.csrWrEnable = 1'b0;
        bus.excSrc      = '0;
        bus.mretValid   = 1'b0;
        checks++;
        if ({bus.trapTrigger, bus.trapReturn} !== {16'h0010, 1'b0}) begin
            failures++;
            $display("FAIL b2b_exc_wins trig=%h ret=%b exp trig=0010 ret=0", bus.trapTrigger, bus.trapReturn);
        end
        csr_read(12'h342, d);
        checks++;
        if (d !== 64'h4) begin failures++; $display("FAIL b2b_mcause got=%h exp=4", d); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] d;
        csr_write(12'h305, 64'h7000);
        bus.redirectReady = 1'b0;
        bus.excSrc        = 16'h0001;
        bus.excPC         = 64'h8000;
        tick();
        bus.excSrc = '0;
        tick();
        checks++;
        if (bus.redirectValid !== 1'b1) begin
            failures++; $display("FAIL rst_mid_in_redir got=%b exp=1", bus.redirectValid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.redirectValid, bus.trapBusy} !== 2'b00) begin
            failures++;
            $display("FAIL rst_mid_idle valid/busy got=%b%b exp=00", bus.redirectValid, bus.trapBusy);
        end
        csr_read(12'h341, d);
        checks++;
        if (d !== 64'h0) begin failures++; $display("FAIL rst_mid_mepc got=%h exp=0", d); end
        csr_read(12'h305, d);
        checks++;
        if (d !== 64'h0) begin failures++; $display("FAIL rst_mid_mtvec got=%h exp=0", d); end
        bus.redirectReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.trapTrigger, bus.trapReturn, bus.redirectValid} !== 18'd0) begin
                failures++;
                $display("FAIL rst_mid_quiet[%0d] got=%h exp=0", i,
                         {bus.trapTrigger, bus.trapReturn, bus.redirectValid});
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_exception();
        test_priority();
        test_vectored_irq();
        test_mret_stall();
        test_irq_gating();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
